truth_table_scanner: RTL and testbench

Sequential stimulus-and-capture stage for the combinational three-input logic blocks (A, B, C -> F). On a start request it steps its outputs through every input combination from 0 to 2^N_IN−1 and drives them into the function under test. After a programmable settle time it samples the function's output for each combination. The result is an assembled truth-table word, plus an optional minterm count, for downstream checking or display.

---
 rtl/truth_table_scanner.sv | 119 +++++++++++
 tb/tb_truth_table_scanner.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: steps abc through every input combination, lets the
// function under test settle for SETTLE cycles per vector, captures f into a
// truth-table word and pulses done when the table is complete.
// Optional macro TT_SCAN_COUNT_EN adds a registered popcount of the table
// (minterm_count); without it minterm_count is tied to zero.
`timescale 1ns/1ps

module truth_table_scanner #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [N_IN-1:0]      abc,
  input  logic                 f,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   truth_table,
  output logic [N_IN:0]        minterm_count
);

  localparam int NV = 2**N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(SETTLE - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]      state;
  logic [N_IN-1:0] idx;
  logic [CW-1:0]   cnt;
  logic [NV-1:0]   table_nxt;
  logic            sample_last;

  // Table with the current f merged in at the current index.
  always_comb begin
    table_nxt      = truth_table;
    table_nxt[idx] = f;
  end

  assign sample_last = (state == S_WAIT) && (cnt == '0) && (idx == IDX_LAST);

  // Scan sequencer. f is captured on the final WAIT edge so each vector costs
  // exactly SETTLE+1 cycles; SAMPLE then advances to the next vector. The last
  // capture goes straight to DONE so done follows the final sample edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      abc         <= '0;
      idx         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            abc         <= '0;
            idx         <= '0;
            truth_table <= '0;
            cnt         <= CNT_INIT;
            busy        <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            truth_table <= table_nxt;
            if (idx == IDX_LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_SAMPLE;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_SAMPLE: begin
          idx   <= idx + IDX_ONE;
          abc   <= idx + IDX_ONE;
          cnt   <= CNT_INIT;
          state <= S_WAIT;
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TT_SCAN_COUNT_EN
  function automatic logic [N_IN:0] popcount(input logic [NV-1:0] v);
    logic [N_IN:0] c;
    c = '0;
    for (int i = 0; i < NV; i++) c = c + {{N_IN{1'b0}}, v[i]};
    return c;
  endfunction

  // Count of ones in the completed table, loaded on the DONE entry edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) minterm_count <= '0;
    else if (sample_last) minterm_count <= popcount(table_nxt);
  end
`else
  assign minterm_count = '0;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: directed and random scans on an N_IN=3
// SETTLE=1 instance, plus a SETTLE=3 instance whose function output lags
// abc by two cycles.
`timescale 1ns/1ps

module tb_truth_table_scanner;

`ifdef TT_SCAN_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, sel3;
  logic start1, start3;
  logic [7:0] tt1, tt3;
  logic [2:0] abc1, abc3, d1, d2;
  logic f1, f3, busy1, busy3, done1, done3;
  logic [7:0] table1, table3;
  logic [3:0] cnt1, cnt3;

  assign start1 = start & ~sel3;
  assign start3 = start & sel3;
  assign f1 = tt1[abc1];

  // Two-stage lag between abc3 and the function input.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= 3'd0;
      d2 <= 3'd0;
    end else begin
      d1 <= abc3;
      d2 <= d1;
    end
  end
  assign f3 = tt3[d2];

  truth_table_scanner #(.N_IN(3), .SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abc(abc1), .f(f1),
    .busy(busy1), .done(done1), .truth_table(table1), .minterm_count(cnt1));

  truth_table_scanner #(.N_IN(3), .SETTLE(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abc(abc3), .f(f3),
    .busy(busy3), .done(done3), .truth_table(table3), .minterm_count(cnt3));

  logic [2:0] abc_m;
  logic busy_m, done_m;
  logic [7:0] table_m;
  logic [3:0] cnt_m;
  always_comb begin
    abc_m   = sel3 ? abc3 : abc1;
    busy_m  = sel3 ? busy3 : busy1;
    done_m  = sel3 ? done3 : done1;
    table_m = sel3 ? table3 : table1;
    cnt_m   = sel3 ? cnt3 : cnt1;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_count(input logic [7:0] t);
    int c;
    c = 0;
    for (int i = 0; i < 8; i++) if (t[i]) c++;
    return CNT_EN ? 4'(c) : 4'd0;
  endfunction

  // One scan: vector k is on abc for t in [k*(S+1), k*(S+1)+S], done
  // follows the last sample edge E = 8*(S+1)-1.
  task automatic scan(input bit use3, input logic [7:0] tt, input string tag, input bit repulse);
    int s, last;
    s = use3 ? 3 : 1;
    last = 8 * (s + 1) - 1;
    sel3 = use3;
    if (use3) tt3 = tt; else tt1 = tt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int t = 0; t <= last; t++) begin
      if (t < last)
        chk({tag, "_step"}, 32'({abc_m, busy_m, done_m}), 32'({3'(t / (s + 1)), 2'b10}));
      else begin
        chk({tag, "_done"}, 32'({abc_m, busy_m, done_m}), 32'({3'd7, 2'b01}));
        chk({tag, "_table"}, 32'(table_m), 32'(tt));
        chk({tag, "_count"}, 32'(cnt_m), 32'(model_count(tt)));
      end
      start = repulse && (t == 3 || t == 9);
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_after"}, 32'({abc_m, busy_m, done_m, table_m}), 32'({3'd7, 2'b00, tt}));
  endtask

  initial begin
    logic [7:0] r;
    bit seen;
    rst_n = 1'b0; start = 1'b0; sel3 = 1'b0; tt1 = 8'h00; tt3 = 8'h00;
    #12;
    chk("rst_s1", 32'({abc1, busy1, done1, table1, cnt1}), 32'd0);
    chk("rst_s3", 32'({abc3, busy3, done3, table3, cnt3}), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    scan(1'b0, 8'hE8, "majority", 1'b0);
    scan(1'b0, 8'h40, "ab_notc", 1'b0);
    scan(1'b0, 8'hFF, "const1", 1'b0);
    scan(1'b0, 8'h00, "const0", 1'b0);
    scan(1'b0, 8'hE8, "repulse", 1'b1);

    // start held high: second scan begins at the first IDLE edge (E+2).
    sel3 = 1'b0; r = 8'($urandom); tt1 = r;
    @(negedge clk); start = 1'b1;
    repeat (16) @(negedge clk);
    chk("hold_done1", 32'({busy1, done1, table1}), 32'({2'b01, r}));
    @(negedge clk);
    chk("hold_idle", 32'({busy1, done1}), 32'd0);
    @(negedge clk);
    chk("hold_restart", 32'({abc1, busy1, done1, table1}), 32'({3'd0, 2'b10, 8'h00}));
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("hold_done2", 32'({busy1, done1, table1}), 32'({2'b01, r}));
    @(negedge clk);

    // Reset mid-scan: after edge 7, bits 0..3 have been captured.
    tt1 = 8'hFF;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_partial", 32'({abc1, busy1, table1}), 32'({3'd3, 1'b1, 8'h0F}));
    #2 rst_n = 1'b0;
    #1 chk("mid_reset", 32'({abc1, busy1, done1, table1, cnt1}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done1 || busy1) seen = 1'b1;
    end
    chk("mid_no_done", 32'(seen), 32'd0);
    scan(1'b0, 8'($urandom), "fresh", 1'b0);

    for (int i = 0; i < 6; i++) scan(1'b0, 8'($urandom), "rand", 1'b0);

    scan(1'b1, 8'hE8, "lag_majority", 1'b0);
    scan(1'b1, 8'($urandom), "lag_rand", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
